// File: rtl/ic_bvashr_sge_skolem_checker_pkg.sv
// Shared types and constants for the bvashr/sge Skolem checker.
package ic_pkg;

    localparam int W_DEF      = 4;
    localparam int SK_LAT_DEF = 1;

    // Controller states; exported on the debug bus as well.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        CHECK  = 3'd2,
        SEARCH = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Golden predicate at the default width: signed(x >>> s) >= signed(t).
    // Shift amounts of W or more fill every bit with x's sign.
    function automatic logic bvashr_sge(input logic [W_DEF-1:0] x,
                                        input logic [W_DEF-1:0] s,
                                        input logic [W_DEF-1:0] t);
        logic signed [W_DEF-1:0] sh;
        sh = $signed(x) >>> s;
        return (sh >= $signed(t));
    endfunction

endpackage

// File: rtl/ic_bvashr_sge_skolem_checker_if.sv
// Bus between the checker and the harness: the Skolem pair/candidate and the
// sweep status. start and abort are single-cycle pulses sampled on the rising
// edge; there is no valid/ready pairing. start is only honoured while the
// checker is idle, abort only while busy, and done pulses for exactly one cycle.
interface ic_bvashr_sge_skolem_checker_if #(parameter int W = 4);

    logic           start;
    logic           abort;
    logic [W-1:0]   sk_s;
    logic [W-1:0]   sk_t;
    logic [W-1:0]   sk_x;
    logic           busy;
    logic           done;
    logic           pass;
    logic [2*W:0]   chk_cnt;
    logic [2*W:0]   fail_cnt;
    logic [2*W:0]   vac_cnt;
    logic           ff_valid;
    logic [W-1:0]   ff_s;
    logic [W-1:0]   ff_t;
    ic_pkg::state_t dbg_state;

    modport master (
        input  start, abort, sk_x,
        output sk_s, sk_t, busy, done, pass, chk_cnt, fail_cnt, vac_cnt,
               ff_valid, ff_s, ff_t, dbg_state
    );

    modport slave (
        output start, abort, sk_x,
        input  sk_s, sk_t, busy, done, pass, chk_cnt, fail_cnt, vac_cnt,
               ff_valid, ff_s, ff_t, dbg_state
    );

endinterface

// File: rtl/ic_bvashr_sge_skolem_checker_pred.sv
// Combinational predicate P(x,s,t) = signed(x >>> s) >=s signed(t).
module ic_bvashr_sge_pred #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         p
);

    logic signed [W-1:0] sh;

    // Arithmetic shift; amounts >= W leave only copies of the sign bit.
    assign sh = $signed(x) >>> s;
    assign p  = (sh >= $signed(t));

endmodule

// File: rtl/ic_bvashr_sge_skolem_checker.sv
// Sweeps every (s,t) pair, checks the external Skolem candidate and falls back
// to a brute-force search over x when the candidate does not satisfy P.
module ic_bvashr_sge_skolem_checker
    import ic_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int SK_LAT = SK_LAT_DEF
) (
    input logic                         clk,
    input logic                         rst_n,
    ic_bvashr_sge_skolem_checker_if.master bus
);

    localparam int IW = 2 * W;
    localparam int CW = 2 * W + 1;
    localparam int LW = (SK_LAT > 1) ? $clog2(SK_LAT) : 1;
    localparam logic [IW-1:0] IDX_LAST = '1;
    localparam logic [W-1:0]  XS_LAST  = '1;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_inc;
    logic [W-1:0]    xs;
    logic [W-1:0]    sk_s_q;
    logic [W-1:0]    sk_t_q;
    logic [W-1:0]    ff_s_q;
    logic [W-1:0]    ff_t_q;
    logic            ff_valid_q;
    logic            pass_q;
    logic [CW-1:0]   chk_q;
    logic [CW-1:0]   fail_q;
    logic [CW-1:0]   vac_q;
    logic [LW-1:0]   lat_cnt;
    logic            lat_last;
    logic            cand_ok;
    logic            srch_hit;
    logic            in_sweep;
    logic            abort_take;

    assign idx_inc    = idx + IW'(1);
    assign lat_last   = (lat_cnt == LW'(SK_LAT - 1));
    assign in_sweep   = (state == DRIVE) || (state == CHECK) ||
                        (state == SEARCH) || (state == NEXT);
    assign abort_take = bus.abort && in_sweep;

    // Candidate path: does the Skolem output satisfy P for the current pair?
    ic_bvashr_sge_pred #(.W(W)) u_cand (
        .x (bus.sk_x),
        .s (sk_s_q),
        .t (sk_t_q),
        .p (cand_ok)
    );

    // Search path: brute-force probe of one x per cycle.
    ic_bvashr_sge_pred #(.W(W)) u_srch (
        .x (xs),
        .s (sk_s_q),
        .t (sk_t_q),
        .p (srch_hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every busy state's own transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DRIVE;
            DRIVE:   if (lat_last) state_nxt = CHECK;
            CHECK:   state_nxt = cand_ok ? NEXT : SEARCH;
            SEARCH:  if (srch_hit || (xs == XS_LAST)) state_nxt = NEXT;
            NEXT:    state_nxt = (idx == IDX_LAST) ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_take) begin
            state_nxt = DONE;
        end
    end

    // Sweep datapath: pair index, Skolem drive, search index, counters, first failure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            xs         <= '0;
            sk_s_q     <= '0;
            sk_t_q     <= '0;
            ff_s_q     <= '0;
            ff_t_q     <= '0;
            ff_valid_q <= 1'b0;
            pass_q     <= 1'b0;
            chk_q      <= '0;
            fail_q     <= '0;
            vac_q      <= '0;
            lat_cnt    <= '0;
        end else begin
            // pass is settled on the edge entering DONE so it is valid with the done pulse.
            if ((state_nxt == DONE) && (state != DONE)) begin
                pass_q <= !abort_take && (fail_q == '0);
            end
            if (!abort_take) begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            idx        <= '0;
                            sk_s_q     <= '0;
                            sk_t_q     <= '0;
                            lat_cnt    <= '0;
                            chk_q      <= '0;
                            fail_q     <= '0;
                            vac_q      <= '0;
                            ff_valid_q <= 1'b0;
                            ff_s_q     <= '0;
                            ff_t_q     <= '0;
                            pass_q     <= 1'b0;
                        end
                    end
                    DRIVE: begin
                        lat_cnt <= lat_last ? '0 : lat_cnt + LW'(1);
                    end
                    CHECK: begin
                        xs <= '0;
                    end
                    SEARCH: begin
                        if (srch_hit) begin
                            fail_q <= fail_q + CW'(1);
                            if (!ff_valid_q) begin
                                ff_valid_q <= 1'b1;
                                ff_s_q     <= sk_s_q;
                                ff_t_q     <= sk_t_q;
                            end
                        end else if (xs == XS_LAST) begin
                            vac_q <= vac_q + CW'(1);
                        end else begin
                            xs <= xs + W'(1);
                        end
                    end
                    NEXT: begin
                        chk_q <= chk_q + CW'(1);
                        idx   <= idx_inc;
                        // The pair is registered on entry to DRIVE so the Skolem
                        // block sees it for the whole latency window.
                        if (idx != IDX_LAST) begin
                            sk_s_q <= idx_inc[IW-1:W];
                            sk_t_q <= idx_inc[W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sk_s      = sk_s_q;
    assign bus.sk_t      = sk_t_q;
    assign bus.busy      = in_sweep;
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass_q;
    assign bus.chk_cnt   = chk_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.vac_cnt   = vac_q;
    assign bus.ff_valid  = ff_valid_q;
    assign bus.ff_s      = ff_s_q;
    assign bus.ff_t      = ff_t_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_ic_bvashr_sge_skolem_checker.sv
// Bench for the bvashr/sge Skolem checker: two instances (latency 1 and 3),
// constant, table-driven and random Skolem candidates, abort and reset cases.
module tb_ic_bvashr_sge_skolem_checker;
    import ic_pkg::*;

    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic       ffv;
        logic [8:0] chk;
        logic [8:0] fail;
        logic [8:0] vac;
        logic [3:0] ffs;
        logic [3:0] fft;
        logic [3:0] sks;
        logic [3:0] skt;
        state_t     st;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ic_bvashr_sge_skolem_checker_if #(.W(W)) bus1 ();
    ic_bvashr_sge_skolem_checker_if #(.W(W)) bus3 ();

    ic_bvashr_sge_skolem_checker #(.W(W), .SK_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    ic_bvashr_sge_skolem_checker #(.W(W), .SK_LAT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0]   exp_q[$];
    logic [W-1:0] cand[N];
    logic [W-1:0] tab1[N];
    logic [W-1:0] tab3[N];
    logic [W-1:0] tab_w[N];
    logic [W-1:0] cval1 = 4'd7;
    bit           mode1 = 1'b0;
    bit           mode3 = 1'b0;
    logic [W-1:0] pipe3[3];

    // Skolem stand-ins: combinational for the latency-1 checker, a 3-stage pipe for the other.
    always_comb bus1.sk_x = mode1 ? tab1[{bus1.sk_s, bus1.sk_t}] : cval1;

    always @(posedge clk) begin
        pipe3[0] <= mode3 ? tab3[{bus3.sk_s, bus3.sk_t}] : 4'b0111;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus3.sk_x = pipe3[2];

    // ---------------- reference model ----------------
    function automatic int sval(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    function automatic bit holds(input int x, input int s, input int t);
        int v;
        v = sval(x);
        v = v >>> s;
        return v >= sval(t);
    endfunction

    // Queues chk, fail, vac, ff_valid, ff_s, ff_t for a full sweep over cand[].
    task automatic model_sweep();
        int fail, vac, ffs, fft;
        bit ffv, wit;
        fail = 0; vac = 0; ffv = 0; ffs = 0; fft = 0;
        for (int i = 0; i < N; i++) begin
            int s, t;
            s = i / (1 << W);
            t = i % (1 << W);
            if (!holds(int'(cand[i]), s, t)) begin
                wit = 0;
                for (int x = 0; x < (1 << W); x++) if (holds(x, s, t)) wit = 1;
                if (wit) begin
                    fail++;
                    if (!ffv) begin ffv = 1; ffs = s; fft = t; end
                end else begin
                    vac++;
                end
            end
        end
        exp_q.push_back(9'(N));
        exp_q.push_back(9'(fail));
        exp_q.push_back(9'(vac));
        exp_q.push_back(9'(ffv));
        exp_q.push_back(9'(ffs));
        exp_q.push_back(9'(fft));
    endtask

    // Fills tab_w with a random witness per pair (correct=1) or with random x.
    task automatic build_tab(input bit correct);
        for (int i = 0; i < N; i++) begin
            int ws[$];
            ws.delete();
            if (correct) begin
                for (int x = 0; x < (1 << W); x++)
                    if (holds(x, i / (1 << W), i % (1 << W))) ws.push_back(x);
            end
            if (ws.size() > 0) tab_w[i] = W'(ws[$urandom_range(ws.size() - 1)]);
            else tab_w[i] = W'($urandom_range((1 << W) - 1));
        end
    endtask

    // ---------------- drivers ----------------
    function automatic obs_t snap(input int which);
        obs_t o;
        if (which == 1) begin
            o = '{bus1.busy, bus1.done, bus1.pass, bus1.ff_valid, bus1.chk_cnt, bus1.fail_cnt,
                  bus1.vac_cnt, bus1.ff_s, bus1.ff_t, bus1.sk_s, bus1.sk_t, bus1.dbg_state};
        end else begin
            o = '{bus3.busy, bus3.done, bus3.pass, bus3.ff_valid, bus3.chk_cnt, bus3.fail_cnt,
                  bus3.vac_cnt, bus3.ff_s, bus3.ff_t, bus3.sk_s, bus3.sk_t, bus3.dbg_state};
        end
        return o;
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 1) bus1.start = v;
        else bus3.start = v;
    endtask

    // Runs one sweep and compares it with the next model entry in exp_q.
    task automatic run_sweep(input int which, input string tag, input bit with_abort,
                             input int extra_starts);
        logic [8:0] e_chk, e_fail, e_vac, e_ffv, e_ffs, e_fft, rec;
        obs_t o;
        bit got;
        e_chk = exp_q.pop_front(); e_fail = exp_q.pop_front(); e_vac = exp_q.pop_front();
        e_ffv = exp_q.pop_front(); e_ffs = exp_q.pop_front(); e_fft = exp_q.pop_front();
        @(negedge clk);
        set_start(which, 1'b1);
        if (with_abort) bus1.abort = 1'b1;
        @(negedge clk);
        set_start(which, 1'b0);
        bus1.abort = 1'b0;
        o = snap(which);
        checks++;
        if (o.busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start got %b want 1", tag, o.busy);
        end
        for (int k = 0; k < extra_starts; k++) begin
            repeat ($urandom_range(200, 20)) @(negedge clk);
            rec = snap(which).chk;
            set_start(which, 1'b1);
            @(negedge clk);
            set_start(which, 1'b0);
            @(negedge clk);
            o = snap(which);
            checks++;
            if (o.busy !== 1'b1 || o.chk < rec) begin
                errors++;
                $display("FAIL %s start_while_busy busy=%b chk=%0d want busy=1 chk>=%0d",
                         tag, o.busy, o.chk, rec);
            end
        end
        got = 0;
        for (int i = 0; i < 8000; i++) begin
            o = snap(which);
            if (o.done === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL %s done_timeout got no done want done", tag); end
        checks++;
        if (o.pass !== (e_fail == 0)) begin
            errors++; $display("FAIL %s pass got %b want %b", tag, o.pass, (e_fail == 0));
        end
        checks++;
        if (o.chk !== e_chk) begin
            errors++; $display("FAIL %s chk_cnt got %0d want %0d", tag, o.chk, e_chk);
        end
        checks++;
        if (o.fail !== e_fail) begin
            errors++; $display("FAIL %s fail_cnt got %0d want %0d", tag, o.fail, e_fail);
        end
        checks++;
        if (o.vac !== e_vac) begin
            errors++; $display("FAIL %s vac_cnt got %0d want %0d", tag, o.vac, e_vac);
        end
        checks++;
        if (o.ffv !== e_ffv[0]) begin
            errors++; $display("FAIL %s ff_valid got %b want %b", tag, o.ffv, e_ffv[0]);
        end
        if (e_ffv[0]) begin
            checks++;
            if (o.ffs !== e_ffs[3:0] || o.fft !== e_fft[3:0]) begin
                errors++;
                $display("FAIL %s ff_st got (%0d,%0d) want (%0d,%0d)", tag, o.ffs, o.fft,
                         e_ffs, e_fft);
            end
        end
        checks++;
        if (o.busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_at_done got %b want 0", tag, o.busy);
        end
        @(negedge clk);
        o = snap(which);
        checks++;
        if (o.done !== 1'b0 || o.st !== IDLE || o.pass !== (e_fail == 0)) begin
            errors++;
            $display("FAIL %s after_done done=%b state=%0d pass=%b want done=0 state=IDLE pass=%b",
                     tag, o.done, o.st, o.pass, (e_fail == 0));
        end
    endtask

    task automatic check_zero(input string tag);
        obs_t o;
        for (int w = 1; w <= 3; w += 2) begin
            o = snap(w);
            checks++;
            if ({o.busy, o.done, o.pass, o.ffv, o.chk, o.fail, o.vac, o.ffs, o.fft, o.sks,
                 o.skt} !== '0 || o.st !== IDLE) begin
                errors++;
                $display("FAIL %s dut%0d outputs got %h state=%0d want all 0 state=IDLE", tag,
                         w, {o.busy, o.done, o.pass, o.ffv, o.chk, o.fail, o.vac, o.ffs, o.fft,
                             o.sks, o.skt}, o.st);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus1.start = 0; bus1.abort = 0; bus3.start = 0; bus3.abort = 0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_const_good();
        mode1 = 0; cval1 = 4'b0111;
        for (int i = 0; i < N; i++) cand[i] = 4'b0111;
        model_sweep();
        run_sweep(1, "const_0111", 0, 0);
    endtask

    task automatic test_const_zero();
        mode1 = 0; cval1 = 4'b0000;
        for (int i = 0; i < N; i++) cand[i] = 4'b0000;
        model_sweep();
        run_sweep(1, "const_0000", 0, 0);
    endtask

    task automatic test_witness_tab();
        build_tab(1);
        for (int i = 0; i < N; i++) begin tab1[i] = tab_w[i]; cand[i] = tab_w[i]; end
        mode1 = 1;
        model_sweep();
        run_sweep(1, "witness_tab", 0, 0);
    endtask

    task automatic test_random_tab();
        build_tab(0);
        for (int i = 0; i < N; i++) begin tab1[i] = tab_w[i]; cand[i] = tab_w[i]; end
        mode1 = 1;
        model_sweep();
        run_sweep(1, "random_tab", 0, 0);
    endtask

    task automatic test_abort();
        obs_t o;
        logic [8:0] c;
        mode1 = 0; cval1 = 4'b0111;
        @(negedge clk); bus1.start = 1;
        @(negedge clk); bus1.start = 0;
        repeat (49) @(negedge clk);
        bus1.abort = 1;
        @(negedge clk);
        bus1.abort = 0;
        o = snap(1);
        checks++;
        if (o.done !== 1'b1 || o.pass !== 1'b0 || o.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_done done=%b pass=%b busy=%b want done=1 pass=0 busy=0",
                     o.done, o.pass, o.busy);
        end
        c = o.chk;
        checks++;
        if (!(o.chk > 0 && o.chk < 9'd256)) begin
            errors++; $display("FAIL abort_chk got %0d want 1..255", o.chk);
        end
        repeat (10) @(negedge clk);
        o = snap(1);
        checks++;
        if (o.chk !== c || o.busy !== 1'b0 || o.done !== 1'b0 || o.pass !== 1'b0) begin
            errors++;
            $display("FAIL abort_frozen chk=%0d busy=%b done=%b pass=%b want chk=%0d 0 0 0",
                     o.chk, o.busy, o.done, o.pass, c);
        end
    endtask

    task automatic test_start_abort_same();
        mode1 = 0; cval1 = 4'b0111;
        for (int i = 0; i < N; i++) cand[i] = 4'b0111;
        model_sweep();
        run_sweep(1, "start_wins", 1, 0);
    endtask

    task automatic test_reset_mid_search();
        bit got;
        mode1 = 0; cval1 = 4'b0111;
        @(negedge clk); bus1.start = 1;
        @(negedge clk); bus1.start = 0;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus1.dbg_state == SEARCH) begin got = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL reach_search got no SEARCH want SEARCH"); end
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_search");
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) cand[i] = 4'b0111;
        model_sweep();
        run_sweep(1, "after_reset", 0, 0);
    endtask

    task automatic test_sklat3();
        mode3 = 0;
        for (int i = 0; i < N; i++) cand[i] = 4'b0111;
        model_sweep();
        run_sweep(3, "lat3_const", 0, 3);
        build_tab(1);
        for (int i = 0; i < N; i++) begin tab3[i] = tab_w[i]; cand[i] = tab_w[i]; end
        mode3 = 1;
        model_sweep();
        run_sweep(3, "lat3_witness", 0, 0);
        build_tab(0);
        for (int i = 0; i < N; i++) begin tab3[i] = tab_w[i]; cand[i] = tab_w[i]; end
        model_sweep();
        run_sweep(3, "lat3_random", 0, 0);
    endtask

    initial begin
        test_reset();
        test_const_good();
        test_const_zero();
        test_witness_tab();
        test_random_tab();
        test_abort();
        test_start_abort_same();
        test_reset_mid_search();
        test_sklat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
